// File: rtl/platform_collider_if.sv
// Request/result bundle between the physics controller and the collision resolver.
// Handshake: start is a one-cycle request taken only while the resolver is idle; done is a one-cycle pulse marking new results.
interface platform_collider_if #(
   parameter int N_ENTRIES = 16
);
   logic                           start;
   logic [9:0]                     cur_x;
   logic [8:0]                     cur_y;
   logic [9:0]                     next_x;
   logic [8:0]                     next_y;
   logic [N_ENTRIES-1:0][28:0]     info_ground;
   logic [N_ENTRIES-1:0][28:0]     info_fence;
   logic                           busy;
   logic                           done;
   logic [9:0]                     res_x;
   logic [8:0]                     res_y;
   logic                           on_ground;
   logic                           hit_left;
   logic                           hit_right;

   modport master (
      output start, cur_x, cur_y, next_x, next_y, info_ground, info_fence,
      input  busy, done, res_x, res_y, on_ground, hit_left, hit_right
   );

   modport slave (
      input  start, cur_x, cur_y, next_x, next_y, info_ground, info_fence,
      output busy, done, res_x, res_y, on_ground, hit_left, hit_right
   );
endinterface

// File: rtl/platform_collider.sv
// Sequential collision resolver: scans ground platforms, then fences, one descriptor per clock,
// and publishes a corrected player position with contact flags.
module platform_collider #(
   parameter int N_ENTRIES = 16,
   parameter int PW        = 16,
   parameter int PH        = 32,
   parameter int X_MAX     = 639
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   platform_collider_if.slave   bus,
   output logic [1:0]           dbg_state_o
);
   localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam logic [10:0] PW11   = 11'(PW);
   localparam logic [10:0] PH11   = 11'(PH);
   localparam logic [10:0] XMAX11 = 11'(X_MAX);
   localparam logic [IW-1:0] LAST = IW'(N_ENTRIES - 1);

   typedef enum logic [1:0] {S_IDLE, S_GROUND, S_FENCE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   // Working copies are kept 11 bits wide so every sum below is free of wrap.
   logic [10:0]   cx_q, cx_d, cy_q, cy_d, nx_q, nx_d, ny_q, ny_d;
   logic [10:0]   by_q, by_d, rx_q, rx_d, lx_q, lx_d;
   logic          og_q, og_d, hr_q, hr_d, hl_q, hl_d;
   logic [9:0]    res_x_q, res_x_d;
   logic [8:0]    res_y_q, res_y_d;
   logic          og_o_q, og_o_d, hl_o_q, hl_o_d, hr_o_q, hr_o_d;
   logic          busy_q, busy_d, done_q, done_d;

   logic [28:0]   g, f;
   logic [10:0]   gx, gy, gl, fy, fx, fl;
   logic [10:0]   g_cand, r_cand, l_cand;
   logic          g_hit, f_ov, r_hit, l_hit;

   always_comb begin
      g      = bus.info_ground[idx_q];
      f      = bus.info_fence[idx_q];
      gx     = {1'b0, g[9:0]};
      gy     = {2'b0, g[18:10]};
      gl     = {1'b0, g[28:19]};
      fy     = {2'b0, f[8:0]};
      fx     = {1'b0, f[18:9]};
      fl     = {1'b0, f[28:19]};
      g_hit  = (gl != 11'd0) && (nx_q + PW11 > gx) && (nx_q < gx + gl) &&
               (cy_q + PH11 <= gy) && (ny_q + PH11 >= gy);
      g_cand = (gy >= PH11) ? gy - PH11 : 11'd0;
      f_ov   = (fl != 11'd0) && (by_q + PH11 > fy) && (by_q < fy + fl);
      r_hit  = f_ov && (cx_q + PW11 <= fx) && (nx_q + PW11 > fx);
      r_cand = (fx >= PW11) ? fx - PW11 : 11'd0;
      l_hit  = f_ov && (cx_q > fx) && (nx_q <= fx);
      l_cand = (fx + 11'd1 > XMAX11) ? XMAX11 : fx + 11'd1;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cx_d    = cx_q;  cy_d = cy_q;  nx_d = nx_q;  ny_d = ny_q;
      by_d    = by_q;  rx_d = rx_q;  lx_d = lx_q;
      og_d    = og_q;  hr_d = hr_q;  hl_d = hl_q;
      res_x_d = res_x_q;
      res_y_d = res_y_q;
      og_o_d  = og_o_q;
      hl_o_d  = hl_o_q;
      hr_o_d  = hr_o_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cx_d    = {1'b0, bus.cur_x};
               cy_d    = {2'b0, bus.cur_y};
               nx_d    = {1'b0, bus.next_x};
               ny_d    = {2'b0, bus.next_y};
               by_d    = {2'b0, bus.next_y};
               rx_d    = {1'b0, bus.next_x};
               lx_d    = {1'b0, bus.next_x};
               og_d    = 1'b0;
               hr_d    = 1'b0;
               hl_d    = 1'b0;
               idx_d   = '0;
               state_d = S_GROUND;
            end
         end
         S_GROUND: begin
            // Strict compare keeps the lower index on equal surfaces.
            if (g_hit && (!og_q || g_cand < by_q)) begin
               by_d = g_cand;
               og_d = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = S_FENCE;
            end
         end
         S_FENCE: begin
            if (r_hit && (!hr_q || r_cand < rx_q)) begin
               rx_d = r_cand;
               hr_d = 1'b1;
            end
            if (l_hit && (!hl_q || l_cand > lx_q)) begin
               lx_d = l_cand;
               hl_d = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
               // Results are published on entry to DONE so they line up with the done pulse.
               idx_d   = '0;
               state_d = S_DONE;
               res_x_d = hr_d ? rx_d[9:0] : (hl_d ? lx_d[9:0] : nx_q[9:0]);
               res_y_d = by_q[8:0];
               og_o_d  = og_q;
               hr_o_d  = hr_d;
               hl_o_d  = hl_d & ~hr_d;
               done_d  = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cx_q    <= '0;  cy_q <= '0;  nx_q <= '0;  ny_q <= '0;
         by_q    <= '0;  rx_q <= '0;  lx_q <= '0;
         og_q    <= 1'b0; hr_q <= 1'b0; hl_q <= 1'b0;
         res_x_q <= '0;
         res_y_q <= '0;
         og_o_q  <= 1'b0;
         hl_o_q  <= 1'b0;
         hr_o_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cx_q    <= cx_d;  cy_q <= cy_d;  nx_q <= nx_d;  ny_q <= ny_d;
         by_q    <= by_d;  rx_q <= rx_d;  lx_q <= lx_d;
         og_q    <= og_d;  hr_q <= hr_d;  hl_q <= hl_d;
         res_x_q <= res_x_d;
         res_y_q <= res_y_d;
         og_o_q  <= og_o_d;
         hl_o_q  <= hl_o_d;
         hr_o_q  <= hr_o_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res_x     = res_x_q;
   assign bus.res_y     = res_y_q;
   assign bus.on_ground = og_o_q;
   assign bus.hit_left  = hl_o_q;
   assign bus.hit_right = hr_o_q;
   assign dbg_state_o   = state_q;
endmodule

// File: doc/platform_collider.md
# platform_collider

Sequential collision resolver that sits directly downstream of the world map ROM. It consumes the 16 ground-platform and 16 fence descriptors every frame, checks a player's proposed move against them one entry per clock, and returns a corrected position plus contact flags. The player/physics controller consumes the result before the next frame's move is computed.

## Interface
Parameters:
- N_ENTRIES, 16: descriptors per array; each scan phase takes this many cycles.
- PW, 16: player box width in pixels.
- PH, 32: player box height in pixels.
- X_MAX, 639: right-most legal x.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cur_x  in  10  current player left edge.
- cur_y  in  9  current player top edge.
- next_x  in  10  proposed left edge.
- next_y  in  9  proposed top edge.
- info_ground  in  29 x N_ENTRIES  [9:0] x_start, [18:10] y_loc, [28:19] length.
- info_fence  in  29 x N_ENTRIES  [8:0] y_start, [18:9] x_loc, [28:19] length.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results update.
- res_x  out  10  resolved left edge.
- res_y  out  9  resolved top edge.
- on_ground  out  1  player rests on or landed on a platform.
- hit_left, hit_right  out  1  fence blocked leftward / rightward motion.

## Operation
- FSM states: IDLE -> GROUND -> FENCE -> DONE -> IDLE.
- IDLE: when start=1, latch cur_x, cur_y, next_x, next_y. Clear the working registers: best_y = next_y, best_x = next_x, and all flags. Go to GROUND with idx=0.
- GROUND: examine info_ground[idx], then increment idx. After idx=N_ENTRIES-1, reset idx to 0 and go to FENCE.
  - Skip the entry if length==0.
  - Horizontal overlap: next_x+PW > x_start and next_x < x_start+length.
  - Landing: overlap and cur_y+PH <= y_loc and next_y+PH >= y_loc.
  - On a hit, the candidate is y_loc-PH, clamped to 0. Keep the smallest y_loc (highest surface). On a tie, the lower index wins. Set on_ground.
- FENCE: examine info_fence[idx] using the resolved best_y. After the last entry, go to DONE.
  - Skip the entry if length==0.
  - Vertical overlap: best_y+PH > y_start and best_y < y_start+length.
  - Right block: overlap and cur_x+PW <= x_loc and next_x+PW > x_loc. Candidate is x_loc-PW, clamped to 0. Keep the smallest candidate. Set hit_right.
  - Left block: overlap and cur_x > x_loc and next_x <= x_loc. Candidate is x_loc+1, clamped to X_MAX. Keep the largest candidate. Set hit_left.
  - If both left and right blocks occur in one request, the right block wins and hit_left stays 0.
- DONE: copy the working registers to res_x, res_y and the flags. Pulse done, drop busy, return to IDLE.
- All comparisons are zero-extended to 11 bits unsigned, so sums never wrap.
- Outputs hold their values between done pulses.
- start while busy is ignored.
- Descriptors must be stable from start until done. The block does not latch the arrays.

## Timing
- Reset: state IDLE, idx 0. busy, done, res_x, res_y, on_ground, hit_left, hit_right all 0.
- Reset_n asserted at any point (including mid-scan) takes effect immediately: no done pulse, all outputs 0.
- Latency, with start sampled at rising edge k:
  - busy is high during cycles k+1 .. k+2N+1.
  - done and the new results are visible during cycle k+2N+1 (33 cycles for N=16).
  - busy is low from k+2N+2.
- Throughput: one request per 2N+2 cycles. A start on the cycle done is high is ignored, because the FSM is not in IDLE on that cycle.

## Test plan
- Floor landing: ground[0]=(0,430,639), others length 0; cur=(300,390), next=(300,405) -> 33 cycles later done=1, res=(300,398), on_ground=1, hit flags 0.
- Highest platform wins: add ground[1]=(100,380,120); cur=(150,340), next=(150,400) -> res_y=348, on_ground=1.
- Right fence: fence[4]=(382,219,48); cur=(200,390), next=(210,390) -> res_x=203, hit_right=1, res_y=390.
- Left fence and no-op:
  - fence[0]=(382,102,48); cur=(110,390), next=(95,390) -> res_x=103, hit_left=1.
  - cur=next=(300,100) with nothing overlapping -> res=(300,100), all flags 0.
- start pulsed again at cycle 5 of busy -> exactly one done, at cycle 33 after the first start; results match the first request.
- Reset_n low at cycle 10 of a scan -> outputs 0 immediately, no done. A fresh start after release completes normally in 33 cycles.
